// File: rtl/lcd_result_writer.sv
// HD44780 write-only driver: power-up init, then repaints "RESULT: v  hdu% " and
// the 16-bit input pattern on request, coalescing requests that arrive while busy.
module lcd_result_writer #(
  parameter int E_PULSE_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLR_WAIT_CYC   = 100000,
  parameter int PWRUP_WAIT_CYC = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        update,
  input  logic        is_o,
  input  logic [6:0]  prob_pct,
  input  logic [15:0] pattern,
  output logic        busy,
  output logic        done,
  output logic        lcd_e,
  output logic        lcd_rw,
  output logic        lcd_rs,
  output logic [7:0]  lcd_data
);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_IDLE, S_L1A, S_L1C, S_L2A, S_L2C, S_FIN
  } state_t;

  typedef enum logic [1:0] { P_SETUP, P_EHI, P_WAIT } phase_t;

  state_t      r_state, w_nstate;
  phase_t      r_ph;
  logic [31:0] r_cnt;
  logic [4:0]  r_idx;
  logic        r_pend;
  logic        r_is_o;
  logic [6:0]  r_prob;
  logic [15:0] r_pat;

  logic        w_wr, w_start, w_wr_done, w_seg_end;
  logic [7:0]  w_byte;
  logic [31:0] w_wait_last;
  logic        w_hun;
  logic [6:0]  w_rem;
  logic [3:0]  w_tens, w_units;

  assign w_wr    = (r_state == S_INIT) || (r_state == S_L1A) || (r_state == S_L1C) ||
                   (r_state == S_L2A)  || (r_state == S_L2C);
  assign w_start = (r_state == S_IDLE) && (update || r_pend);

  // Snapshot is already clamped to 100, so hundreds is a single bit.
  assign w_hun = (r_prob == 7'd100);
  assign w_rem = w_hun ? 7'd0 : r_prob;

  always_comb begin
    w_tens = 4'd0;
    for (int k = 1; k < 10; k++)
      if (w_rem >= 7'(10 * k)) w_tens = 4'(k);
  end

  assign w_units = 4'(w_rem - 7'(w_tens) * 7'd10);

  always_comb begin
    w_byte = 8'h00;
    unique case (r_state)
      S_INIT: begin
        case (r_idx)
          5'd0, 5'd1, 5'd2: w_byte = 8'h38;
          5'd3:             w_byte = 8'h0C;
          5'd4:             w_byte = 8'h06;
          default:          w_byte = 8'h01;
        endcase
      end
      S_L1A: w_byte = 8'h80;
      S_L2A: w_byte = 8'hC0;
      S_L1C: begin
        case (r_idx[3:0])
          4'd0:    w_byte = 8'h52;
          4'd1:    w_byte = 8'h45;
          4'd2:    w_byte = 8'h53;
          4'd3:    w_byte = 8'h55;
          4'd4:    w_byte = 8'h4C;
          4'd5:    w_byte = 8'h54;
          4'd6:    w_byte = 8'h3A;
          4'd8:    w_byte = r_is_o ? 8'h4F : 8'h58;
          4'd11:   w_byte = {7'b0011000, w_hun};
          4'd12:   w_byte = {4'h3, w_tens};
          4'd13:   w_byte = {4'h3, w_units};
          4'd14:   w_byte = 8'h25;
          default: w_byte = 8'h20;
        endcase
      end
      S_L2C:   w_byte = r_pat[r_idx[3:0]] ? 8'h23 : 8'h2E;
      default: w_byte = 8'h00;
    endcase
  end

  // Only the clear-display command gets the long settle time.
  assign w_wait_last = ((r_state == S_INIT) && (w_byte == 8'h01)) ?
                       32'(CLR_WAIT_CYC - 1) : 32'(CMD_WAIT_CYC - 1);
  assign w_wr_done   = w_wr && (r_ph == P_WAIT) && (r_cnt == w_wait_last);

  always_comb begin
    w_seg_end = 1'b0;
    case (r_state)
      S_INIT:       w_seg_end = (r_idx == 5'd5);
      S_L1A, S_L2A: w_seg_end = 1'b1;
      S_L1C, S_L2C: w_seg_end = (r_idx == 5'd15);
      default:      w_seg_end = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_PWRUP;
    else      r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_PWRUP: if (r_cnt == 32'(PWRUP_WAIT_CYC - 1)) w_nstate = S_INIT;
      S_INIT:  if (w_wr_done && w_seg_end) w_nstate = S_IDLE;
      S_IDLE:  if (w_start) w_nstate = S_L1A;
      S_L1A:   if (w_wr_done) w_nstate = S_L1C;
      S_L1C:   if (w_wr_done && w_seg_end) w_nstate = S_L2A;
      S_L2A:   if (w_wr_done) w_nstate = S_L2C;
      S_L2C:   if (w_wr_done && w_seg_end) w_nstate = S_FIN;
      S_FIN:   w_nstate = S_IDLE;
      default: w_nstate = S_PWRUP;
    endcase
  end

  always_comb begin
    lcd_e    = w_wr && (r_ph == P_EHI);
    lcd_rs   = w_wr && ((r_state == S_L1C) || (r_state == S_L2C));
    lcd_data = w_wr ? w_byte : 8'h00;
    lcd_rw   = 1'b0;
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ph   <= P_SETUP;
      r_cnt  <= '0;
      r_idx  <= '0;
      r_pend <= 1'b0;
      r_is_o <= 1'b0;
      r_prob <= '0;
      r_pat  <= '0;
    end else begin
      if (update && (r_state != S_IDLE)) r_pend <= 1'b1;
      else if (w_start)                  r_pend <= 1'b0;

      if (w_start) begin
        r_is_o <= is_o;
        r_prob <= (prob_pct > 7'd100) ? 7'd100 : prob_pct;
        r_pat  <= pattern;
      end

      if (r_state == S_PWRUP) begin
        r_ph  <= P_SETUP;
        r_cnt <= r_cnt + 32'd1;
      end else if (w_wr) begin
        unique case (r_ph)
          P_SETUP: begin
            r_ph  <= P_EHI;
            r_cnt <= '0;
          end
          P_EHI: begin
            if (r_cnt == 32'(E_PULSE_CYC - 1)) begin
              r_ph  <= P_WAIT;
              r_cnt <= '0;
            end else r_cnt <= r_cnt + 32'd1;
          end
          P_WAIT: begin
            if (w_wr_done) begin
              r_ph  <= P_SETUP;
              r_cnt <= '0;
            end else r_cnt <= r_cnt + 32'd1;
          end
          default: r_ph <= P_SETUP;
        endcase
      end else begin
        r_ph  <= P_SETUP;
        r_cnt <= '0;
      end

      // Character index restarts at every line/segment change.
      if (w_wr_done)  r_idx <= w_seg_end ? 5'd0 : r_idx + 5'd1;
      else if (!w_wr) r_idx <= 5'd0;
    end
  end

endmodule

// File: tb/tb_lcd_result_writer.sv
// Bench for lcd_result_writer: bus monitor captures every E-strobed byte and is
// compared against a text-level model of the init list and the two display lines.
module tb_lcd_result_writer;
  localparam int EP = 2;
  localparam int CW = 4;
  localparam int CL = 8;
  localparam int PW = 16;
  localparam int NW = 1 + EP + CW;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        update = 1'b0;
  logic        is_o = 1'b0;
  logic [6:0]  prob_pct = '0;
  logic [15:0] pattern = '0;
  logic        busy, done, lcd_e, lcd_rw, lcd_rs;
  logic [7:0]  lcd_data;

  lcd_result_writer #(
    .E_PULSE_CYC(EP), .CMD_WAIT_CYC(CW), .CLR_WAIT_CYC(CL), .PWRUP_WAIT_CYC(PW)
  ) dut (
    .clk(clk), .rst(rst), .update(update), .is_o(is_o), .prob_pct(prob_pct),
    .pattern(pattern), .busy(busy), .done(done), .lcd_e(lcd_e), .lcd_rw(lcd_rw),
    .lcd_rs(lcd_rs), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [8:0] cap[$];
  logic [8:0] expq[$];
  int done_cnt = 0;
  int gap_idle = 0;
  int low_run = 0;
  int ewid = 0;
  int dwid = 0;
  logic e_q = 1'b0, d_q = 1'b0, b_q = 1'b1;
  logic [8:0] ev = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Bus monitor: record each write at the E rising edge, check width and hold at fall.
  always @(negedge clk) begin
    if (!rst) begin
      ewid = 0; dwid = 0; low_run = 0; ev = '0;
    end else begin
      if (b_q && !busy) gap_idle = low_run;
      if (lcd_e) begin
        if (!e_q) begin
          cap.push_back({lcd_rs, lcd_data});
          ev = {lcd_rs, lcd_data};
          ewid = 0;
          chk("rw_low", lcd_rw, 1'b0);
        end
        ewid++;
        low_run = 0;
      end else begin
        if (e_q) begin
          chk("e_width", ewid, EP);
          chk("bus_hold", {lcd_rs, lcd_data}, ev);
        end
        low_run++;
      end
      if (done) begin
        if (!d_q) done_cnt++;
        dwid++;
      end else begin
        if (d_q) chk("done_width", dwid, 1);
        dwid = 0;
      end
    end
    e_q = rst ? lcd_e : 1'b0;
    d_q = rst ? done : 1'b0;
    b_q = rst ? busy : 1'b1;
  end

  task automatic add_init();
    expq.push_back(9'h038); expq.push_back(9'h038); expq.push_back(9'h038);
    expq.push_back(9'h00C); expq.push_back(9'h006); expq.push_back(9'h001);
  endtask

  task automatic add_rep(input bit o, input int p, input logic [15:0] pat);
    string s;
    s = $sformatf("RESULT: %s  %03d%% ", o ? "O" : "X", (p > 100) ? 100 : p);
    expq.push_back(9'h080);
    for (int i = 0; i < 16; i++) expq.push_back({1'b1, 8'(s[i])});
    expq.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) expq.push_back({1'b1, pat[i] ? 8'h23 : 8'h2E});
  endtask

  task automatic cmp_bus(input string tag);
    int n;
    chk({tag, "_count"}, cap.size(), expq.size());
    n = (cap.size() < expq.size()) ? cap.size() : expq.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_w%0d", tag, i), cap[i], expq[i]);
    cap.delete();
    expq.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    chk("rst_vals", {lcd_e, lcd_rs, lcd_rw, busy, done, lcd_data}, {5'b00010, 8'h00});
    tick();
    tick();
    cap.delete();
    expq.delete();
    done_cnt = 0;
    rst = 1'b1;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin tick(); n++; end
    chk("idle_reached", busy, 1'b0);
  endtask

  task automatic wait_done(input int target, input int lim);
    int n = 0;
    while (done_cnt < target && n < lim) begin tick(); n++; end
    chk("done_seen", done_cnt, target);
  endtask

  task automatic wait_cap(input int target, input int lim);
    int n = 0;
    while (cap.size() < target && n < lim) begin tick(); n++; end
    chk("writes_seen", cap.size() >= target, 1'b1);
  endtask

  task automatic repaint(input bit o, input int p, input logic [15:0] pat);
    int lat;
    done_cnt = 0;
    is_o = o; prob_pct = 7'(p); pattern = pat;
    update = 1'b1;
    tick();
    update = 1'b0;
    lat = 1;
    while (!done && lat < 2000) begin tick(); lat++; end
    chk("latency", (lat >= 34 * NW) && (lat <= 34 * NW + 4), 1'b1);
    tick();
    chk("one_done", done_cnt, 1);
    add_rep(o, p, pat);
    cmp_bus($sformatf("rep_o%0d_p%0d", o, p));
  endtask

  initial begin
    int fe;
    logic [15:0] pat1, pat2;
    bit o1;

    // Init sequence and its timing.
    do_reset();
    fe = 0;
    while (!lcd_e && fe < 200) begin tick(); fe++; end
    chk("pwrup_len", fe, PW + 1);
    wait_idle(500);
    chk("clr_gap", gap_idle, CL);
    add_init();
    cmp_bus("init");
    tick();

    repaint(1'b1, 87, 16'h8001);
    repaint(1'b0, 120, 16'h0000);
    repaint(1'b1, 100, 16'hFFFF);
    repaint(1'b0, 0, 16'h5A5A);
    for (int r = 0; r < 4; r++)
      repaint(1'($urandom_range(0, 1)), int'($urandom_range(0, 127)), 16'($urandom));

    // Snapshot: inputs move mid-repaint without a new request.
    done_cnt = 0;
    pat1 = 16'($urandom);
    is_o = 1'b1; prob_pct = 7'd5; pattern = pat1;
    update = 1'b1;
    tick();
    update = 1'b0;
    repeat (30) tick();
    prob_pct = 7'd99; pattern = ~pat1; is_o = 1'b0;
    wait_done(1, 1000);
    repeat (400) tick();
    chk("snap_no_extra", done_cnt, 1);
    add_rep(1'b1, 5, pat1);
    cmp_bus("snapshot");

    // Coalescing: three requests during init, two during the first repaint.
    pat1 = 16'($urandom);
    pat2 = 16'($urandom);
    o1 = 1'($urandom_range(0, 1));
    is_o = o1; prob_pct = 7'd42; pattern = pat1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      update = 1'b1; tick(); update = 1'b0; tick();
    end
    wait_cap(11, 3000);
    is_o = ~o1; prob_pct = 7'd113; pattern = pat2;
    update = 1'b1; tick(); update = 1'b0;
    repeat (20) tick();
    update = 1'b1; tick(); update = 1'b0;
    wait_done(2, 3000);
    repeat (400) tick();
    chk("coalesce_dones", done_cnt, 2);
    add_init();
    add_rep(o1, 42, pat1);
    add_rep(~o1, 113, pat2);
    cmp_bus("coalesce");

    // Reset during the 10th line-1 character, with a request pending.
    done_cnt = 0;
    is_o = 1'b1; prob_pct = 7'd64; pattern = 16'h1234;
    update = 1'b1; tick(); update = 1'b0;
    wait_cap(3, 1000);
    update = 1'b1; tick(); update = 1'b0;
    wait_cap(11, 1000);
    chk("mid_byte", cap[10], {1'b1, 8'h20});
    do_reset();
    wait_idle(2000);
    repeat (400) tick();
    chk("rst_no_repaint", done_cnt, 0);
    chk("rst_idle", busy, 1'b0);
    add_init();
    cmp_bus("rst_replay");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
